// File: rtl/mfp_ahb_lite_master.sv
// AHB-Lite initiator: single commands in, pipelined SINGLE transfers out, in-order responses.
// Handles wait states, two-cycle ERROR with cancel-and-replay, and local misalignment errors.
module mfp_ahb_lite_master #(
  parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,

  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        idle,

  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  // Address stage
  logic        a_valid;
  logic        a_lerr;
  logic [31:0] a_addr;
  logic [2:0]  a_size;
  logic        a_write;
  logic [31:0] a_wdata;
  logic        a_replay;

  // Data stage
  logic        d_valid;
  logic        d_lerr;
  logic        d_write;

  logic        err1;
  logic        cmd_misaligned;
  logic        d_err;

  assign err1      = d_valid & ~HREADY & HRESP;
  assign cmd_ready = HREADY & ~err1 & ~a_replay;
  assign d_err     = HRESP | d_lerr;

  always_comb begin
    cmd_misaligned = 1'b0;
    unique case (cmd_size)
      3'd0:    cmd_misaligned = 1'b0;
      3'd1:    cmd_misaligned = cmd_addr[0];
      3'd2:    cmd_misaligned = (cmd_addr[1:0] != 2'b00);
      default: cmd_misaligned = 1'b1;
    endcase
  end

  assign HADDR     = a_addr;
  assign HSIZE     = a_size;
  assign HWRITE    = a_write;
  assign HTRANS    = (a_valid & ~a_lerr) ? 2'b10 : 2'b00;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VALUE;

  assign idle = ~a_valid & ~d_valid & ~a_replay & ~rsp_valid;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid   <= 1'b0;
      a_lerr    <= 1'b0;
      a_addr    <= 32'h0;
      a_size    <= 3'd0;
      a_write   <= 1'b0;
      a_wdata   <= 32'h0;
      a_replay  <= 1'b0;
      d_valid   <= 1'b0;
      d_lerr    <= 1'b0;
      d_write   <= 1'b0;
      HWDATA    <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_error <= 1'b0;
    end else if (HREADY) begin
      d_valid <= a_valid;
      d_lerr  <= a_lerr;
      d_write <= a_write;
      HWDATA  <= a_wdata;

      // Replay reissues the cancelled transfer from the retained A contents.
      if (a_replay) begin
        a_valid  <= 1'b1;
        a_replay <= 1'b0;
      end else if (cmd_valid && cmd_ready) begin
        a_valid <= 1'b1;
        a_lerr  <= cmd_misaligned;
        a_addr  <= cmd_addr;
        a_size  <= cmd_size;
        a_write <= cmd_write;
        a_wdata <= cmd_wdata;
      end else begin
        a_valid <= 1'b0;
      end

      if (d_valid) begin
        rsp_valid <= 1'b1;
        rsp_error <= d_err;
        rsp_rdata <= (!d_write && !d_err) ? HRDATA : 32'h0;
      end else begin
        rsp_valid <= 1'b0;
        rsp_error <= 1'b0;
        rsp_rdata <= 32'h0;
      end
    end else begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= 32'h0;
      // First ERROR cycle: cancel a pending bus transfer so HTRANS is IDLE next cycle.
      if (err1 && a_valid && !a_lerr) begin
        a_valid  <= 1'b0;
        a_replay <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Directed bench for mfp_ahb_lite_master: single-command vector table plus pipelined,
// wait-state, ERROR-replay, misalignment and mid-transfer reset sequences.
module tb_mfp_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        idle;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int passed = 0;
  int total  = 0;

  mfp_ahb_lite_master #(.HPROT_VALUE(4'b0011)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .idle      (idle),
    .HADDR     (HADDR),
    .HBURST    (HBURST),
    .HMASTLOCK (HMASTLOCK),
    .HPROT     (HPROT),
    .HSIZE     (HSIZE),
    .HTRANS    (HTRANS),
    .HWDATA    (HWDATA),
    .HWRITE    (HWRITE),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    logic [1:0]  exp_trans;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  // Each cycle starts 1 time unit after the rising edge; checks happen at the falling edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic mid();
    @(negedge HCLK);
  endtask

  task automatic do_vector(input vec_t v, input int idx);
    tick();
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_size  = v.size;
    cmd_wdata = v.wdata;
    HRDATA    = v.hrdata;
    mid();
    check($sformatf("v%0d cmd_ready", idx), {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    mid();
    check($sformatf("v%0d HTRANS", idx), {30'b0, HTRANS}, {30'b0, v.exp_trans});
    check($sformatf("v%0d HADDR", idx), HADDR, v.addr);
    check($sformatf("v%0d HSIZE", idx), {29'b0, HSIZE}, {29'b0, v.size});
    check($sformatf("v%0d HWRITE", idx), {31'b0, HWRITE}, {31'b0, v.wr});
    tick();
    mid();
    check($sformatf("v%0d HWDATA", idx), HWDATA, v.wdata);
    check($sformatf("v%0d HTRANS idle", idx), {30'b0, HTRANS}, 32'd0);
    check($sformatf("v%0d rsp early", idx), {31'b0, rsp_valid}, 32'd0);
    tick();
    mid();
    check($sformatf("v%0d rsp_valid", idx), {31'b0, rsp_valid}, 32'd1);
    check($sformatf("v%0d rsp_error", idx), {31'b0, rsp_error}, {31'b0, v.exp_err});
    check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    tick();
    mid();
    check($sformatf("v%0d rsp end", idx), {31'b0, rsp_valid}, 32'd0);
    check($sformatf("v%0d idle", idx), {31'b0, idle}, 32'd1);
  endtask

  logic [1:0]  s4_trans [7];
  logic        s4_rv    [7];
  logic        s4_err   [7];
  logic [31:0] s4_rdata [7];

  initial begin
    vecs[0] = '{1'b0, 32'h1FC0_0000, 3'd2, 32'h0, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0100, 3'd2, 32'h1234_5678, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_0202, 3'd1, 32'h0, 32'h0000_ABCD, 2'b10, 1'b0, 32'h0000_ABCD};
    vecs[3] = '{1'b0, 32'h0000_0203, 3'd0, 32'h0, 32'h0000_0055, 2'b10, 1'b0, 32'h0000_0055};
    vecs[4] = '{1'b0, 32'h0000_0201, 3'd1, 32'h0, 32'hAAAA_AAAA, 2'b00, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 32'h0000_0306, 3'd2, 32'h0BAD_0BAD, 32'h0, 2'b00, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 32'h0000_0300, 3'd3, 32'h0, 32'h5555_5555, 2'b00, 1'b1, 32'h0};

    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_size  = 3'd0;
    cmd_wdata = 32'h0;
    HRDATA    = 32'h0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;

    #2;
    check("reset HTRANS", {30'b0, HTRANS}, 32'd0);
    check("reset HADDR", HADDR, 32'd0);
    check("reset HWDATA", HWDATA, 32'd0);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset idle", {31'b0, idle}, 32'd1);
    check("HPROT", {28'b0, HPROT}, 32'h3);
    #10;
    HRESETn = 1'b1;

    for (int i = 0; i < 7; i++) do_vector(vecs[i], i);

    // Four back-to-back writes with HREADY held high.
    cmd_write = 1'b1;
    cmd_size  = 3'd2;
    for (int c = 0; c < 8; c++) begin
      tick();
      cmd_valid = (c < 4);
      cmd_addr  = 32'(4 * c);
      cmd_wdata = 32'(c + 1);
      mid();
      if (c >= 1 && c <= 4) begin
        check($sformatf("b2b c%0d HTRANS", c), {30'b0, HTRANS}, 32'd2);
        check($sformatf("b2b c%0d HADDR", c), HADDR, 32'(4 * (c - 1)));
      end
      if (c >= 2 && c <= 5) check($sformatf("b2b c%0d HWDATA", c), HWDATA, 32'(c - 1));
      check($sformatf("b2b c%0d rsp_valid", c), {31'b0, rsp_valid},
            {31'b0, (c >= 3 && c <= 6)});
    end

    // Write then read with two wait states in the write data phase.
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'hA5A5_A5A5;
    HRDATA = 32'hCAFE_F00D;
    mid();
    tick();
    cmd_write = 1'b0; cmd_addr = 32'h4;
    mid();
    check("ws accept read", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0; HREADY = 1'b0;
    for (int c = 2; c < 4; c++) begin
      if (c == 3) tick();
      mid();
      check($sformatf("ws c%0d HTRANS", c), {30'b0, HTRANS}, 32'd2);
      check($sformatf("ws c%0d HADDR", c), HADDR, 32'h4);
      check($sformatf("ws c%0d cmd_ready", c), {31'b0, cmd_ready}, 32'd0);
      check($sformatf("ws c%0d HWDATA", c), HWDATA, 32'hA5A5_A5A5);
    end
    tick();
    HREADY = 1'b1;
    mid();
    check("ws c4 HTRANS", {30'b0, HTRANS}, 32'd2);
    check("ws c4 rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    mid();
    check("ws wr rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("ws wr rsp_rdata", rsp_rdata, 32'h0);
    check("ws wr rsp_error", {31'b0, rsp_error}, 32'd0);
    tick();
    mid();
    check("ws rd rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("ws rd rsp_rdata", rsp_rdata, 32'hCAFE_F00D);

    // ERROR on a write, with a read queued behind it that must be replayed once.
    tick();
    mid();
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h77;
    mid();
    tick();
    cmd_write = 1'b0; cmd_addr = 32'h14;
    mid();
    tick();
    cmd_valid = 1'b0; HREADY = 1'b0; HRESP = 1'b1;
    mid();
    check("err c2 cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("err c2 HTRANS", {30'b0, HTRANS}, 32'd2);
    tick();
    HREADY = 1'b1;
    mid();
    check("err c3 HTRANS cancel", {30'b0, HTRANS}, 32'd0);
    check("err c3 cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("err c3 idle", {31'b0, idle}, 32'd0);
    tick();
    HRESP = 1'b0; HRDATA = 32'h1357_2468;
    mid();
    check("err wr rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("err wr rsp_error", {31'b0, rsp_error}, 32'd1);
    check("err wr rsp_rdata", rsp_rdata, 32'h0);
    check("err replay HTRANS", {30'b0, HTRANS}, 32'd2);
    check("err replay HADDR", HADDR, 32'h14);
    check("err replay HWRITE", {31'b0, HWRITE}, 32'd0);
    for (int c = 5; c < 10; c++) begin
      tick();
      mid();
      check($sformatf("err c%0d rsp_valid", c), {31'b0, rsp_valid}, {31'b0, (c == 6)});
      if (c == 6) begin
        check("err rd rsp_error", {31'b0, rsp_error}, 32'd0);
        check("err rd rsp_rdata", rsp_rdata, 32'h1357_2468);
      end
    end

    // Misaligned read between two aligned reads.
    s4_trans = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    s4_rv    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    s4_err   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    s4_rdata = '{32'h0, 32'h0, 32'h0, 32'h1111_1111, 32'h0, 32'h3333_3333, 32'h0};
    cmd_write = 1'b0; cmd_size = 3'd2;
    for (int c = 0; c < 7; c++) begin
      tick();
      cmd_valid = (c < 3);
      cmd_addr  = (c == 0) ? 32'h40 : (c == 1) ? 32'h2 : 32'h48;
      HRDATA    = (c == 2) ? 32'h1111_1111 : (c == 3) ? 32'h2222_2222 : 32'h3333_3333;
      mid();
      check($sformatf("mis c%0d HTRANS", c), {30'b0, HTRANS}, {30'b0, s4_trans[c]});
      check($sformatf("mis c%0d rsp_valid", c), {31'b0, rsp_valid}, {31'b0, s4_rv[c]});
      check($sformatf("mis c%0d rsp_error", c), {31'b0, rsp_error}, {31'b0, s4_err[c]});
      check($sformatf("mis c%0d rsp_rdata", c), rsp_rdata, s4_rdata[c]);
    end

    // Asynchronous reset while a read sits in a wait state.
    tick();
    cmd_valid = 1'b1; cmd_addr = 32'h80;
    mid();
    tick();
    cmd_valid = 1'b0;
    mid();
    tick();
    HREADY = 1'b0;
    mid();
    tick();
    #2;
    HRESETn = 1'b0;
    #1;
    check("rst HTRANS", {30'b0, HTRANS}, 32'd0);
    check("rst idle", {31'b0, idle}, 32'd1);
    check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    #3;
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      mid();
      check($sformatf("post-rst c%0d rsp_valid", c), {31'b0, rsp_valid}, 32'd0);
      check($sformatf("post-rst c%0d HTRANS", c), {30'b0, HTRANS}, 32'd0);
    end
    do_vector('{1'b0, 32'h0000_00C0, 3'd2, 32'h0, 32'h9ABC_DEF0, 2'b10, 1'b0, 32'h9ABC_DEF0}, 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
